// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
//   Shared constants for the multiplexed seven-segment display path:
//   digit count, special BCD codes and segment patterns.
//   Segment bytes are {a,b,c,d,e,f,g,dp}, active-high.
// ---------------------------------------------------------------------------
package disp_pkg;

   localparam int NUM_DIGITS = 8;

   // Nibble codes beyond 0-9
   localparam logic [3:0] DIG_DASH  = 4'd10;
   localparam logic [3:0] DIG_BLANK = 4'd11;   // 11..15 all render blank

   localparam logic [7:0] SEG_0     = 8'hFC;
   localparam logic [7:0] SEG_1     = 8'h60;
   localparam logic [7:0] SEG_2     = 8'hDA;
   localparam logic [7:0] SEG_3     = 8'hF2;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'hB6;
   localparam logic [7:0] SEG_6     = 8'hBE;
   localparam logic [7:0] SEG_7     = 8'hE0;
   localparam logic [7:0] SEG_8     = 8'hFE;
   localparam logic [7:0] SEG_9     = 8'hF6;
   localparam logic [7:0] SEG_DASH  = 8'h02;
   localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//   Combinational nibble -> segment decoder.
//   Ports:
//     digit  in  4   BCD nibble (10 = dash, 11-15 = blank)
//     seg    out 8   {a,b,c,d,e,f,g,dp}, active-high
// ---------------------------------------------------------------------------
module seg7_decode
   import disp_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:     seg = SEG_0;
         4'd1:     seg = SEG_1;
         4'd2:     seg = SEG_2;
         4'd3:     seg = SEG_3;
         4'd4:     seg = SEG_4;
         4'd5:     seg = SEG_5;
         4'd6:     seg = SEG_6;
         4'd7:     seg = SEG_7;
         4'd8:     seg = SEG_8;
         4'd9:     seg = SEG_9;
         DIG_DASH: seg = SEG_DASH;
         default:  seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
//   Shares the 8-digit multiplexed seven-segment display between N_REQ
//   requesters. Owns digit scanning, per-digit blink and segment decode.
//   Ownership only changes at frame boundaries (fixed priority, highest
//   index wins, with a minimum hold before preemption), so a frame is never
//   a mix of two requesters.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     req         per-requester level request
//     digits      8 BCD nibbles per requester, digit 0 in the top nibble
//     blink       per-digit blink mask per requester, bit 7 = digit 0
//     gnt         one-hot current owner, zero when idle
//     frame_done  1-clk pulse after the digit-7 slot ends
//     seg_data1/2 segment pattern (two identical banks)
//     seg_which   one-hot digit select, bit 7 = digit 0
// ---------------------------------------------------------------------------
module seg_display_arbiter
   import disp_pkg::*;
#(
   parameter int N_REQ           = 3,
   parameter int SCAN_DIV        = 200000,
   parameter int BLINK_DIV       = 50000000,
   parameter int MIN_HOLD_FRAMES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*32-1:0] digits,
   input  logic [N_REQ*8-1:0]  blink,
   output logic [N_REQ-1:0]    gnt,
   output logic                frame_done,
   output logic [7:0]          seg_data1,
   output logic [7:0]          seg_data2,
   output logic [7:0]          seg_which
);

   localparam int OWN_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int HOLD_W  = (MIN_HOLD_FRAMES > 0) ? $clog2(MIN_HOLD_FRAMES + 1) : 1;

   logic [SCAN_W-1:0]  scan_cnt;
   logic [2:0]         idx;
   logic               tick;
   logic               frame_end;

   logic               owner_vld;
   logic [OWN_W-1:0]   owner;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_ph;
   logic [31:0]        sh_digits;
   logic [7:0]         sh_blink;

   logic               win_vld;
   logic [OWN_W-1:0]   win;
   logic               switch_own;
   logic               nxt_vld;
   logic [OWN_W-1:0]   nxt_owner;
   logic [31:0]        nxt_digits;
   logic [7:0]         nxt_blink;
   logic [N_REQ-1:0]   nxt_gnt;

   logic [3:0]         cur_nib;
   logic [7:0]         cur_seg;
   logic [7:0]         cur_sel;
   logic               cur_show;

   assign tick      = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign frame_end = tick && (idx == 3'd7);

   // Highest-index active request; ascending loop lets later hits override.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i]) begin
            win_vld = 1'b1;
            win     = OWN_W'(i);
         end
      end
   end

   // An owner that drops its request is released at once; a live owner
   // can only be preempted after holding the display long enough.
   always_comb begin
      switch_own = 1'b0;
      if (!owner_vld)
         switch_own = win_vld;
      else if (!req[owner])
         switch_own = 1'b1;
      else if ((win != owner) && (hold_cnt >= HOLD_W'(MIN_HOLD_FRAMES)))
         switch_own = 1'b1;
   end

   assign nxt_vld   = switch_own ? win_vld : owner_vld;
   assign nxt_owner = switch_own ? win : owner;

   always_comb begin
      nxt_digits = '0;
      nxt_blink  = '0;
      nxt_gnt    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (nxt_vld && (nxt_owner == OWN_W'(i))) begin
            nxt_digits = digits[i*32 +: 32];
            nxt_blink  = blink[i*8 +: 8];
            nxt_gnt[i] = 1'b1;
         end
      end
   end

   // Slot idx shows digit idx: top nibble / top mask bit is digit 0,
   // so the bit position is (7 - idx), i.e. ~idx.
   assign cur_nib  = sh_digits[{~idx, 2'b00} +: 4];
   assign cur_sel  = 8'h80 >> idx;
   assign cur_show = owner_vld && !(sh_blink[~idx] && blink_ph);

   seg7_decode u_decode (
      .digit (cur_nib),
      .seg   (cur_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt   <= '0;
         idx        <= '0;
         frame_done <= 1'b0;
         owner_vld  <= 1'b0;
         owner      <= '0;
         gnt        <= '0;
         hold_cnt   <= '0;
         blink_cnt  <= '0;
         blink_ph   <= 1'b0;
         sh_digits  <= '0;
         sh_blink   <= '0;
         seg_which  <= '0;
         seg_data1  <= '0;
         seg_data2  <= '0;
      end else begin
         scan_cnt   <= tick ? '0 : scan_cnt + 1'b1;
         frame_done <= frame_end;
         if (tick)
            idx <= idx + 1'b1;

         if (frame_end && switch_own) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
         end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         // Shadow reload: everything the next frame shows is frozen here.
         if (frame_end) begin
            owner_vld <= nxt_vld;
            owner     <= nxt_owner;
            gnt       <= nxt_gnt;
            sh_digits <= nxt_digits;
            sh_blink  <= nxt_blink;
            if (switch_own)
               hold_cnt <= '0;
            else if (hold_cnt < HOLD_W'(MIN_HOLD_FRAMES))
               hold_cnt <= hold_cnt + 1'b1;
         end

         // The slot's pattern is registered as its tick completes, using the
         // shadow of the frame the slot belongs to.
         if (tick) begin
            seg_which <= cur_show ? cur_sel : 8'h00;
            seg_data1 <= cur_show ? cur_seg : 8'h00;
            seg_data2 <= cur_show ? cur_seg : 8'h00;
         end
      end
   end

endmodule
